// File: rtl/button_pulser.sv
// ---------------------------------------------------------------------------
// button_pulser : N-channel button debouncer with press and auto-repeat strobes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_pulser_ch #(
  parameter int DEBOUNCE      = 100000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic pushed_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic pulse_next_o,
  output logic held_o
);

  localparam int DBW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]  DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  logic           meta_q;
  logic           sync_q;
  logic           samp_q;
  logic [DBW-1:0] db_cnt_q;
  logic [DBW-1:0] db_cnt_d;
  logic           held_q;
  logic           held_d;
  logic [TW-1:0]  tmr_q;
  logic [TW-1:0]  tmr_d;
  state_t         state_q;
  state_t         state_d;
  logic           pulse_q;
  logic           pulse_d;
  logic           rise;
  logic           fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      samp_q   <= 1'b0;
      db_cnt_q <= '0;
      held_q   <= 1'b0;
      tmr_q    <= '0;
      state_q  <= ST_IDLE;
      pulse_q  <= 1'b0;
    end else begin
      meta_q   <= pushed_i;
      sync_q   <= meta_q;
      samp_q   <= sync_q;
      db_cnt_q <= db_cnt_d;
      held_q   <= held_d;
      tmr_q    <= tmr_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
    end
  end

  // The stability counter restarts whenever the sampled level agrees with held.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    if (samp_q != held_q) begin
      if (db_cnt_q == DB_LAST) begin
        held_d = ~held_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  assign rise = ~held_q &  held_d;
  assign fall =  held_q & ~held_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (rise) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (!repeat_en_i) begin
          tmr_d = '0;
        end else if (tmr_q == DELAY_LAST) begin
          state_d = ST_REPEAT;
          tmr_d   = '0;
          pulse_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_REPEAT: begin
        // Release wins over a coinciding timer expiry.
        if (fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (!repeat_en_i) begin
          state_d = ST_PRESSED;
          tmr_d   = '0;
        end else if (tmr_q == PERIOD_LAST) begin
          tmr_d   = '0;
          pulse_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  assign pulse_o      = pulse_q;
  assign pulse_next_o = pulse_d;
  assign held_o       = held_q;

endmodule

module button_pulser #(
  parameter int N             = 4,
  parameter int DEBOUNCE      = 100000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pushed,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] pulse,
  output logic [N-1:0] held,
  output logic         any_pulse
);

  logic [N-1:0] pulse_d;
  logic         any_pulse_q;

  generate
    for (genvar g = 0; g < N; g++) begin : g_ch
      button_pulser_ch #(
        .DEBOUNCE      (DEBOUNCE),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .pushed_i     (pushed[g]),
        .repeat_en_i  (repeat_en[g]),
        .pulse_o      (pulse[g]),
        .pulse_next_o (pulse_d[g]),
        .held_o       (held[g])
      );
    end
  endgenerate

  // Built from the channels' next-state strobes so it lines up with pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse_d;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_button_pulser.sv
// ---------------------------------------------------------------------------
// tb_button_pulser : directed bench with a cycle-level reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_pulser;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] pushed = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] pulse;
  logic [N-1:0] held;
  logic         any_pulse;

  always #5 clk = ~clk;

  button_pulser #(
    .N             (N),
    .DEBOUNCE      (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pushed    (pushed),
    .repeat_en (repeat_en),
    .pulse     (pulse),
    .held      (held),
    .any_pulse (any_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: held toggles once the level seen three edges late has
  // disagreed with it for DB consecutive edges; repeat pulses land RD edges
  // after the last press/disable edge and then every RP edges.
  int           edge_n = -1;
  int           rst_edge = -1;
  bit           started = 1'b0;
  bit           hist [N][MAXE];
  bit           m_held [N];
  int           base [N];
  logic [N-1:0] m_pulse = '0;
  bit           tog;
  int           plog0 [$];
  int           plog1 [$];

  function automatic bit eff(input int c, input int j);
    if (j < 0 || j <= rst_edge) return 1'b0;
    return hist[c][j];
  endfunction

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (reset) begin
      started  = 1'b1;
      rst_edge = edge_n;
      m_pulse  = '0;
      for (int c = 0; c < N; c++) begin
        m_held[c] = 1'b0;
        base[c]   = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (edge_n < MAXE) hist[c][edge_n] = pushed[c];
        tog = 1'b1;
        for (int i = 0; i < DB; i++)
          if (eff(c, edge_n - 3 - i) == m_held[c]) tog = 1'b0;
        m_pulse[c] = 1'b0;
        if (tog && !m_held[c]) begin
          m_pulse[c] = 1'b1;
          base[c]    = edge_n;
        end else if (m_held[c] && !tog) begin
          if (!repeat_en[c]) base[c] = edge_n;
          else if ((edge_n - base[c]) >= RD && ((edge_n - base[c] - RD) % RP) == 0)
            m_pulse[c] = 1'b1;
        end
        if (tog) m_held[c] = !m_held[c];
      end
    end
    #1;
    if (started) begin
      chk("model_pulse", 32'(pulse), 32'(m_pulse));
      chk("model_held", 32'(held), 32'({m_held[1], m_held[0]}));
      chk("model_any", 32'(any_pulse), 32'(|m_pulse));
    end
    if (pulse[0] === 1'b1) plog0.push_back(edge_n);
    if (pulse[1] === 1'b1) plog1.push_back(edge_n);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int exp_rel [8];

  task automatic chk_pulses(input string name, input int c, input int from,
                            input int start, input int n);
    int sz;
    int v;
    sz = (c == 0) ? plog0.size() : plog1.size();
    chk({name, "_count"}, 32'(sz - from), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (from + i < sz) begin
        v = (c == 0) ? plog0[from + i] : plog1[from + i];
        chk({name, "_at"}, 32'(v - start), 32'(exp_rel[i]));
      end
    end
  endtask

  int start;
  int from;

  initial begin
    reset = 1'b1;
    step(3);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_any", 32'(any_pulse), 32'd0);
    reset = 1'b0;
    step(5);

    // single press, no repeat
    from = plog0.size(); start = edge_n + 1; pushed[0] = 1'b1;
    step(6); chk("t1_held_pre", 32'(held[0]), 32'd0);
    step(1); chk("t1_held_rise", 32'(held[0]), 32'd1);
    chk("t1_pulse", 32'(pulse[0]), 32'd1);
    step(13); pushed[0] = 1'b0;
    step(6); chk("t1_held_still", 32'(held[0]), 32'd1);
    step(1); chk("t1_held_fall", 32'(held[0]), 32'd0);
    exp_rel[0] = 6;
    chk_pulses("t1", 0, from, start, 1);
    step(3);

    // short glitch is rejected
    from = plog0.size(); pushed[0] = 1'b1;
    step(3); pushed[0] = 1'b0;
    step(12);
    chk("t2_npulse", 32'(plog0.size() - from), 32'd0);
    chk("t2_held", 32'(held[0]), 32'd0);

    // auto-repeat on ch1
    from = plog1.size(); start = edge_n + 1; repeat_en[1] = 1'b1; pushed[1] = 1'b1;
    step(30); pushed[1] = 1'b0;
    step(12); repeat_en[1] = 1'b0;
    exp_rel[0] = 6;  exp_rel[1] = 16; exp_rel[2] = 19; exp_rel[3] = 22;
    exp_rel[4] = 25; exp_rel[5] = 28; exp_rel[6] = 31; exp_rel[7] = 34;
    chk_pulses("t3", 1, from, start, 8);

    // repeat enable dropped and restored
    from = plog1.size(); start = edge_n + 1; repeat_en[1] = 1'b1; pushed[1] = 1'b1;
    step(18); repeat_en[1] = 1'b0;
    step(4);  repeat_en[1] = 1'b1;
    step(8);  pushed[1] = 1'b0;
    step(12); repeat_en[1] = 1'b0;
    exp_rel[0] = 6; exp_rel[1] = 16; exp_rel[2] = 31; exp_rel[3] = 34;
    chk_pulses("t4", 1, from, start, 4);

    // simultaneous press
    pushed = 2'b11;
    step(7);
    chk("t5_pulse", 32'(pulse), 32'd3);
    chk("t5_any", 32'(any_pulse), 32'd1);
    step(1);
    chk("t5_pulse_end", 32'(pulse), 32'd0);
    chk("t5_any_end", 32'(any_pulse), 32'd0);
    pushed = 2'b00;
    step(12);

    // reset during repeat with button still held
    repeat_en[1] = 1'b1; pushed[1] = 1'b1;
    step(19); reset = 1'b1;
    step(1);
    chk("t6_rst_pulse", 32'(pulse), 32'd0);
    chk("t6_rst_held", 32'(held), 32'd0);
    chk("t6_rst_any", 32'(any_pulse), 32'd0);
    reset = 1'b0;
    step(6); chk("t6_pulse_pre", 32'(pulse[1]), 32'd0);
    step(1); chk("t6_pulse", 32'(pulse[1]), 32'd1);
    chk("t6_held", 32'(held[1]), 32'd1);
    pushed[1] = 1'b0; repeat_en[1] = 1'b0;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
